mem_port_unit: RTL

Parametrised MAR/MDR memory port for the LC-3b datapath: holds the memory address and data registers and runs a multi-cycle, wait-state-configurable handshake to the external asynchronous SRAM. It sits between the internal 16-bit bus and the SRAM pins. The control FSM issues one-cycle requests. The unit reports busy and a one-cycle ready pulse, so memory states no longer need hand-counted wait cycles.

---
 rtl/lc3b_types.sv | 69 ++++++
 rtl/lc3b_register.sv | 18 +
 rtl/mem_wait_ctr.sv | 24 ++
 rtl/mem_port_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b shared types: memory port states, strobe bundle, decode helpers
package lc3b_types;

  localparam int LC3B_MEM_WAIT_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } lc3b_mem_state;

  // Everything the memory port drives besides address/data; registered as one bundle.
  typedef struct packed {
    logic busy;
    logic ready;
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
    logic wdata_oe;
  } mem_pins_t;

  // Pin levels for the state being entered; lanes_n is {ub_n, lb_n} for the access.
  function automatic mem_pins_t mem_pins(lc3b_mem_state s, logic wr, logic [1:0] lanes_n);
    mem_pins_t p;
    p.busy     = 1'b1;
    p.ready    = 1'b0;
    p.ce_n     = 1'b1;
    p.oe_n     = 1'b1;
    p.we_n     = 1'b1;
    p.ub_n     = 1'b1;
    p.lb_n     = 1'b1;
    p.wdata_oe = 1'b0;
    case (s)
      IDLE: p.busy = 1'b0;
      SETUP: begin
        p.ce_n           = 1'b0;
        {p.ub_n, p.lb_n} = lanes_n;
        p.oe_n           = wr;
        p.wdata_oe       = wr;
      end
      ACCESS: begin
        p.ce_n           = 1'b0;
        {p.ub_n, p.lb_n} = lanes_n;
        p.oe_n           = wr;
        p.we_n           = !wr;
        p.wdata_oe       = wr;
      end
      HOLD: begin
        p.ce_n           = 1'b0;
        {p.ub_n, p.lb_n} = lanes_n;
        p.wdata_oe       = 1'b1;
      end
      DONE: p.ready = 1'b1;
      default: p.busy = 1'b0;
    endcase
    return p;
  endfunction

  // Lane enables {ub_n, lb_n}: a byte write selects one lane by address bit 0.
  function automatic logic [1:0] lane_n(logic wr, logic bsel, logic a0);
    if (wr && bsel) return a0 ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

endpackage

// File: rtl/lc3b_register.sv
// rtl/lc3b_register.sv - width-parametrised load-enable register with sync active-low reset
module lc3b_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold value unless loaded; reset clears.
  always_ff @(posedge clk) begin
    if (!resetn) q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/mem_wait_ctr.sv
// rtl/mem_wait_ctr.sv - loadable down-counter with zero flag for SRAM wait states
module mem_wait_ctr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!resetn) count <= '0;
    else if (load) count <= load_val;
    else if (dec && count != '0) count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_unit.sv
// rtl/mem_port_unit.sv - LC-3b MAR/MDR SRAM port; define MEM_BYTE_LANE_EN for byte-lane writes
module mem_port_unit
  import lc3b_types::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = LC3B_MEM_WAIT_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              req,
  input  logic              we,
  input  logic              byte_sel,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              ready,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_ub_n,
  output logic              mem_lb_n
);

  localparam int CTR_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  lc3b_mem_state     state;
  mem_pins_t         pins;
  logic              op_we;
  logic              op_byte;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              ctr_zero;
  logic              in_idle;
  logic              mdr_cap;
  logic [1:0]        req_lanes_n;
  logic [1:0]        cur_lanes_n;

  assign in_idle = (state == IDLE);
  // Read data lands in MDR on the final ACCESS edge; no other MDR load while busy.
  assign mdr_cap = (state == ACCESS) && !op_we && ctr_zero;

  lc3b_register #(.WIDTH(ADDR_W)) u_mar (
    .clk    (Clk),
    .resetn (Reset),
    .ld     (in_idle && ld_mar),
    .d      (ADDR_W'(bus_in)),
    .q      (mar)
  );

  lc3b_register #(.WIDTH(DATA_W)) u_mdr (
    .clk    (Clk),
    .resetn (Reset),
    .ld     ((in_idle && ld_mdr) || mdr_cap),
    .d      (mdr_cap ? mem_rdata : bus_in),
    .q      (mdr)
  );

  mem_wait_ctr #(.W(CTR_W)) u_wait (
    .clk      (Clk),
    .resetn   (Reset),
    .load     (state == SETUP),
    .load_val (CTR_W'(WAIT_CYCLES)),
    .dec      (state == ACCESS),
    .zero     (ctr_zero)
  );

`ifdef MEM_BYTE_LANE_EN
  logic mar_next0;
  // Lane choice at the request edge must see a MAR bit loaded on that same edge.
  assign mar_next0   = (in_idle && ld_mar) ? bus_in[0] : mar[0];
  assign req_lanes_n = lane_n(we, byte_sel, mar_next0);
  assign cur_lanes_n = lane_n(op_we, op_byte, mar[0]);
  assign mem_wdata   = op_byte ? {2{mdr[DATA_W/2-1:0]}} : mdr;
`else
  logic unused_op_byte;
  assign unused_op_byte = op_byte;
  assign req_lanes_n    = 2'b00;
  assign cur_lanes_n    = 2'b00;
  assign mem_wdata      = mdr;
`endif

  // Access sequencer: pins are registered alongside the state they belong to.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      op_we   <= 1'b0;
      op_byte <= 1'b0;
      pins    <= mem_pins(IDLE, 1'b0, 2'b11);
    end else begin
      case (state)
        IDLE: if (req) begin
          state   <= SETUP;
          op_we   <= we;
          op_byte <= byte_sel;
          pins    <= mem_pins(SETUP, we, req_lanes_n);
        end
        SETUP: begin
          state <= ACCESS;
          pins  <= mem_pins(ACCESS, op_we, cur_lanes_n);
        end
        ACCESS: if (ctr_zero) begin
          if (op_we) begin
            state <= HOLD;
            pins  <= mem_pins(HOLD, op_we, cur_lanes_n);
          end else begin
            state <= DONE;
            pins  <= mem_pins(DONE, op_we, cur_lanes_n);
          end
        end
        HOLD: begin
          state <= DONE;
          pins  <= mem_pins(DONE, op_we, cur_lanes_n);
        end
        DONE: begin
          state <= IDLE;
          pins  <= mem_pins(IDLE, op_we, cur_lanes_n);
        end
        default: begin
          state <= IDLE;
          pins  <= mem_pins(IDLE, 1'b0, 2'b11);
        end
      endcase
    end
  end

  assign ADDR         = mar;
  assign mdr_out      = mdr;
  assign busy         = pins.busy;
  assign ready        = pins.ready;
  assign mem_ce_n     = pins.ce_n;
  assign mem_oe_n     = pins.oe_n;
  assign mem_we_n     = pins.we_n;
  assign mem_ub_n     = pins.ub_n;
  assign mem_lb_n     = pins.lb_n;
  assign mem_wdata_oe = pins.wdata_oe;

endmodule
